clause_array_ctrl: RTL and testbench
====================================

Name: clause_array_ctrl

Overview:
Sequencer in front of clause_array. It loads a bin of up to NUM_CLAUSES clauses into the array through a valid/ready stream, driving the one-hot row writes. It then runs implication passes to a fixed point, reporting SAT-progress, conflict or iteration timeout, and issues backtrack pulses on request. Sits between the bin manager (upstream) and clause_array (downstream). Owns wr_i, clause_i, clause_len_i, var_value_i, var_lvl_i, apply_impl_i and apply_bkt_i.

Parameters:
NUM_CLAUSES, 8, rows in clause_array
NUM_VARS, 8, variables per bin
WIDTH_LVL, 16, decision-level width
WIDTH_C_LEN, 5, clause-length field width
MAX_ITER, 16, implication-pass limit before timeout (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ld_valid_i  in  1  clause word valid
ld_ready_o  out  1  controller accepts clause word
ld_clause_i  in  NUM_VARS*2  literals, 2b/var: 00 absent, 01 positive, 10 negative
ld_len_i  in  WIDTH_C_LEN  literal count
ld_last_i  in  1  final clause of bin
start_i  in  1  begin propagation (1-cycle pulse)
value_init_i  in  NUM_VARS*3  initial var states
lvl_init_i  in  NUM_VARS*WIDTH_LVL  initial var levels
bkt_i  in  1  backtrack request (1-cycle pulse)
bkt_lvl_i  in  WIDTH_LVL  backtrack target level
busy_o  out  1  not IDLE/READY
done_o  out  1  1-cycle pulse at end of load, propagation or backtrack
conflict_o  out  1  valid with done_o: propagation ended in conflict
timeout_o  out  1  valid with done_o: MAX_ITER reached
value_o  out  NUM_VARS*3  latched var states
lvl_o  out  NUM_VARS*WIDTH_LVL  latched var levels
ca_wr_o  out  NUM_CLAUSES  one-hot row write
ca_clause_o  out  NUM_VARS*2  clause to array
ca_len_o  out  WIDTH_C_LEN  length to array
ca_value_o  out  NUM_VARS*3  var_value_i of array
ca_value_i  in  NUM_VARS*3  var_value_o of array
ca_lvl_o  out  NUM_VARS*WIDTH_LVL  var_lvl_i of array
ca_lvl_i  in  NUM_VARS*WIDTH_LVL  var_lvl_o of array
ca_impl_o  out  1  apply_impl_i
ca_bkt_o  out  1  apply_bkt_i

Behaviour:
- Var state: {implied, val[1:0]}; val 00 free, 01 true, 10 false, 11 conflict.
- Reset (sync, rst=1): state IDLE; every output 0; row pointer 0; value/lvl registers 0.
- States: IDLE, LOAD, FLUSH, READY, PROP, WAIT, BKT.
- IDLE: ld_ready_o=1; a handshake (valid&ready) enters LOAD.
- LOAD: every handshake registers ca_wr_o = 1<<ptr, ca_clause_o, ca_len_o for exactly one cycle (1-cycle latency), then ptr++. After ld_last_i, or after NUM_CLAUSES rows, ld_ready_o drops.
- FLUSH: rows ptr..NUM_CLAUSES-1 are written with an all-zero clause, len 0, one row per cycle, so no stale clause survives. Then done_o pulses and the state goes to READY. ld_valid beyond NUM_CLAUSES rows is not accepted (ready=0).
- READY: start_i latches value_init_i/lvl_init_i and enters PROP. bkt_i enters BKT. start_i and bkt_i in the same cycle: bkt wins. start/bkt in IDLE/LOAD/FLUSH is ignored.
- PROP: ca_value_o/ca_lvl_o are driven from the registers, ca_impl_o=1 for one cycle, then WAIT.
- WAIT: ca_value_i/ca_lvl_i are sampled into the registers and the iteration count is incremented. Exits are checked in priority order:
  - any val==11: done, conflict_o=1
  - sampled == previous: done, fixed point
  - count==MAX_ITER: done, timeout_o=1
  - otherwise return to PROP
  - All three done exits go to READY.
- BKT: one cycle. Every var with lvl > bkt_lvl_i gets state and lvl set to 0. ca_bkt_o=1 with the cleared values driven. Then done_o and READY.
- ca_wr_o is never nonzero outside LOAD/FLUSH; ca_impl_o and ca_bkt_o are never high together.
- rst mid-operation returns to IDLE next edge; the array contents are not cleared.
- New bin: a fresh handshake while in READY restarts LOAD at ptr 0.

Decomposition:
- Shared package sat_bin_pkg holds:
  - lit codes (LIT_NONE/POS/NEG)
  - var-val codes (VAL_FREE/TRUE/FALSE/CONFLICT)
  - controller state enum
  - helper function any_conflict(vector)
- One sub-module, ca_bkt_mask: combinational per-var level compare and clear. The FSM stays in the top module.

Test Plan:
- Load 5 clauses {2,0,1,0..},{0,2,0,1,0,2..},{2,0,0,1,2..},{1,1,0,0,1..},{0,1,2,0,2..}, ld_last on 5th -> ca_wr_o 00000001..00010000, then 3 zero-clause flush writes, done_o after 8th row.
- Back-pressure: ld_valid held continuously for 9 clauses without last -> exactly 8 accepted, ld_ready_o=0 on 9th, no flush rows.
- Propagate on bin above with init vals {0,2,0,0,0,2,0,0}, levels 1..8 -> ca_impl_o pulses until ca_value_i is stable, done_o with conflict_o=0, value_o equals final array output.
- Array model returning val 11 on var 3 in pass 2 -> done_o after 2nd WAIT with conflict_o=1.
- Array model toggling value every pass, MAX_ITER=4 -> done_o with timeout_o=1 after 4 passes.
- bkt_i with bkt_lvl_i=3, levels 1..8 -> vars 3..7 cleared, ca_bkt_o high 1 cycle. Simultaneous start_i ignored. rst during PROP -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sat_bin_pkg.sv
// Shared codes and helpers for the clause-array sequencer.
// Literal/value encodings and the controller state set.
package sat_bin_pkg;

    localparam int MAX_VARS = 64;
    localparam int VEC_W    = MAX_VARS * 3;

    localparam logic [1:0] LIT_NONE = 2'b00;
    localparam logic [1:0] LIT_POS  = 2'b01;
    localparam logic [1:0] LIT_NEG  = 2'b10;

    localparam logic [1:0] VAL_FREE     = 2'b00;
    localparam logic [1:0] VAL_TRUE     = 2'b01;
    localparam logic [1:0] VAL_FALSE    = 2'b10;
    localparam logic [1:0] VAL_CONFLICT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_READY,
        S_PROP,
        S_WAIT,
        S_BKT
    } ctrl_state_e;

    // Callers zero-extend; padded vars read as free.
    function automatic logic any_conflict(input logic [VEC_W-1:0] vec);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_VARS; i++) begin
            if (vec[3*i +: 2] == VAL_CONFLICT) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ca_bkt_mask.sv
// Backtrack mask: clears every var whose level exceeds the target.
// Purely combinational; the controller registers the result.
module ca_bkt_mask
    import sat_bin_pkg::*;
#(
    parameter int NUM_VARS  = 8,
    parameter int WIDTH_LVL = 16
) (
    input  logic [NUM_VARS*3-1:0]         value,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] lvl,
    input  logic [WIDTH_LVL-1:0]          bkt_lvl,
    output logic [NUM_VARS*3-1:0]         value_clr,
    output logic [NUM_VARS*WIDTH_LVL-1:0] lvl_clr
);

    always_comb begin
        value_clr = value;
        lvl_clr   = lvl;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (lvl[i*WIDTH_LVL +: WIDTH_LVL] > bkt_lvl) begin
                value_clr[3*i +: 3]             = {1'b0, VAL_FREE};
                lvl_clr[i*WIDTH_LVL +: WIDTH_LVL] = '0;
            end
        end
    end

endmodule

// File: rtl/clause_array_ctrl.sv
// Sequencer for clause_array: bin load with flush, implication
// passes to a fixed point, and backtrack pulses.
module clause_array_ctrl
    import sat_bin_pkg::*;
#(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_LVL   = 16,
    parameter int WIDTH_C_LEN = 5,
    parameter int MAX_ITER    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ld_valid_i,
    output logic                          ld_ready_o,
    input  logic [NUM_VARS*2-1:0]         ld_clause_i,
    input  logic [WIDTH_C_LEN-1:0]        ld_len_i,
    input  logic                          ld_last_i,
    input  logic                          start_i,
    input  logic [NUM_VARS*3-1:0]         value_init_i,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] lvl_init_i,
    input  logic                          bkt_i,
    input  logic [WIDTH_LVL-1:0]          bkt_lvl_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          conflict_o,
    output logic                          timeout_o,
    output logic [NUM_VARS*3-1:0]         value_o,
    output logic [NUM_VARS*WIDTH_LVL-1:0] lvl_o,
    output logic [NUM_CLAUSES-1:0]        ca_wr_o,
    output logic [NUM_VARS*2-1:0]         ca_clause_o,
    output logic [WIDTH_C_LEN-1:0]        ca_len_o,
    output logic [NUM_VARS*3-1:0]         ca_value_o,
    input  logic [NUM_VARS*3-1:0]         ca_value_i,
    output logic [NUM_VARS*WIDTH_LVL-1:0] ca_lvl_o,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] ca_lvl_i,
    output logic                          ca_impl_o,
    output logic                          ca_bkt_o
);

    localparam int PW = $clog2(NUM_CLAUSES + 1);
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int VW = NUM_VARS * 3;
    localparam int LW = NUM_VARS * WIDTH_LVL;

    localparam logic [PW-1:0] PTR_END  = PW'(NUM_CLAUSES);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_CLAUSES - 1);
    localparam logic [IW-1:0] ITER_END = IW'(MAX_ITER);
    localparam logic [NUM_CLAUSES-1:0] ROW0 = NUM_CLAUSES'(1);

    ctrl_state_e state, state_n;

    logic [PW-1:0]          ptr, ptr_n;
    logic [IW-1:0]          iter, iter_n;
    logic [VW-1:0]          value_q, value_n, mask_value;
    logic [LW-1:0]          lvl_q, lvl_n, mask_lvl;
    logic [WIDTH_LVL-1:0]   bkt_lvl_q, bkt_lvl_n;
    logic                   ready_n, busy_n, done_n;
    logic                   conflict_n, timeout_n;
    logic [NUM_CLAUSES-1:0] wr_n;
    logic [NUM_VARS*2-1:0]  clause_n;
    logic [WIDTH_C_LEN-1:0] len_n;
    logic                   hs, last_row, stable, conf;

    assign hs       = ld_valid_i & ld_ready_o;
    assign last_row = (ptr == PTR_LAST);
    assign conf     = any_conflict(VEC_W'(ca_value_i));
    assign stable   = (ca_value_i == value_q) && (ca_lvl_i == lvl_q);

    ca_bkt_mask #(
        .NUM_VARS  (NUM_VARS),
        .WIDTH_LVL (WIDTH_LVL)
    ) u_mask (
        .value     (value_q),
        .lvl       (lvl_q),
        .bkt_lvl   (bkt_lvl_q),
        .value_clr (mask_value),
        .lvl_clr   (mask_lvl)
    );

    assign ca_impl_o  = (state == S_PROP);
    assign ca_bkt_o   = (state == S_BKT);
    assign ca_value_o = ca_bkt_o ? mask_value : value_q;
    assign ca_lvl_o   = ca_bkt_o ? mask_lvl : lvl_q;
    assign value_o    = value_q;
    assign lvl_o      = lvl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        iter_n     = iter;
        value_n    = value_q;
        lvl_n      = lvl_q;
        bkt_lvl_n  = bkt_lvl_q;
        done_n     = 1'b0;
        conflict_n = 1'b0;
        timeout_n  = 1'b0;
        wr_n       = '0;
        clause_n   = '0;
        len_n      = '0;
        unique case (state)
            S_IDLE, S_READY: begin
                // An accepted word always starts a fresh bin at row 0.
                if (hs) begin
                    wr_n     = ROW0;
                    clause_n = ld_clause_i;
                    len_n    = ld_len_i;
                    ptr_n    = PW'(1);
                    if (ld_last_i || (NUM_CLAUSES == 1)) begin
                        state_n = S_FLUSH;
                    end else begin
                        state_n = S_LOAD;
                    end
                end else if (state == S_READY && bkt_i) begin
                    bkt_lvl_n = bkt_lvl_i;
                    state_n   = S_BKT;
                end else if (state == S_READY && start_i) begin
                    value_n = value_init_i;
                    lvl_n   = lvl_init_i;
                    iter_n  = '0;
                    state_n = S_PROP;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    wr_n     = ROW0 << ptr;
                    clause_n = ld_clause_i;
                    len_n    = ld_len_i;
                    ptr_n    = ptr + 1'b1;
                    if (ld_last_i || last_row) begin
                        state_n = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (ptr == PTR_END) begin
                    done_n  = 1'b1;
                    state_n = S_READY;
                end else begin
                    wr_n     = ROW0 << ptr;
                    clause_n = {NUM_VARS{LIT_NONE}};
                    ptr_n    = ptr + 1'b1;
                end
            end
            S_PROP: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                value_n = ca_value_i;
                lvl_n   = ca_lvl_i;
                iter_n  = iter + 1'b1;
                if (conf) begin
                    done_n     = 1'b1;
                    conflict_n = 1'b1;
                    state_n    = S_READY;
                end else if (stable) begin
                    done_n  = 1'b1;
                    state_n = S_READY;
                end else if (iter_n == ITER_END) begin
                    done_n    = 1'b1;
                    timeout_n = 1'b1;
                    state_n   = S_READY;
                end else begin
                    state_n = S_PROP;
                end
            end
            S_BKT: begin
                value_n = mask_value;
                lvl_n   = mask_lvl;
                done_n  = 1'b1;
                state_n = S_READY;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        ready_n = (state_n == S_IDLE) || (state_n == S_LOAD) ||
                  (state_n == S_READY);
        busy_n  = !((state_n == S_IDLE) || (state_n == S_READY));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            iter        <= '0;
            value_q     <= '0;
            lvl_q       <= '0;
            bkt_lvl_q   <= '0;
            ld_ready_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            conflict_o  <= 1'b0;
            timeout_o   <= 1'b0;
            ca_wr_o     <= '0;
            ca_clause_o <= '0;
            ca_len_o    <= '0;
        end else begin
            ptr         <= ptr_n;
            iter        <= iter_n;
            value_q     <= value_n;
            lvl_q       <= lvl_n;
            bkt_lvl_q   <= bkt_lvl_n;
            ld_ready_o  <= ready_n;
            busy_o      <= busy_n;
            done_o      <= done_n;
            conflict_o  <= conflict_n;
            timeout_o   <= timeout_n;
            ca_wr_o     <= wr_n;
            ca_clause_o <= clause_n;
            ca_len_o    <= len_n;
        end
    end

endmodule

// File: tb/tb_clause_array_ctrl.sv
// Directed bench for clause_array_ctrl with a small array response model.
// Runs with MAX_ITER=4 so the timeout path is reachable quickly.
module tb_clause_array_ctrl;

    localparam int NC  = 8;
    localparam int NV  = 8;
    localparam int WL  = 16;
    localparam int WCL = 5;
    localparam int MI  = 4;

    localparam logic [23:0]  V_INIT = 24'h010010;
    localparam logic [23:0]  V_A    = 24'h010015;
    localparam logic [23:0]  V_B    = 24'h010195;
    localparam logic [23:0]  V_C    = 24'h010615;
    localparam logic [23:0]  V_K    = 24'h000195;
    localparam logic [127:0] L_INIT =
        128'h0008_0007_0006_0005_0004_0003_0002_0001;
    localparam logic [127:0] L_K =
        128'h0000_0000_0000_0000_0000_0003_0002_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              ld_valid_i, ld_ready_o, ld_last_i;
    logic [NV*2-1:0]   ld_clause_i;
    logic [WCL-1:0]    ld_len_i;
    logic              start_i, bkt_i;
    logic [NV*3-1:0]   value_init_i;
    logic [NV*WL-1:0]  lvl_init_i;
    logic [WL-1:0]     bkt_lvl_i;
    logic              busy_o, done_o, conflict_o, timeout_o;
    logic [NV*3-1:0]   value_o;
    logic [NV*WL-1:0]  lvl_o;
    logic [NC-1:0]     ca_wr_o;
    logic [NV*2-1:0]   ca_clause_o;
    logic [WCL-1:0]    ca_len_o;
    logic [NV*3-1:0]   ca_value_o;
    logic [NV*3-1:0]   ca_value_i = '0;
    logic [NV*WL-1:0]  ca_lvl_o;
    logic [NV*WL-1:0]  ca_lvl_i = '0;
    logic              ca_impl_o, ca_bkt_o;

    clause_array_ctrl #(
        .NUM_CLAUSES (NC),
        .NUM_VARS    (NV),
        .WIDTH_LVL   (WL),
        .WIDTH_C_LEN (WCL),
        .MAX_ITER    (MI)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid_i   (ld_valid_i),
        .ld_ready_o   (ld_ready_o),
        .ld_clause_i  (ld_clause_i),
        .ld_len_i     (ld_len_i),
        .ld_last_i    (ld_last_i),
        .start_i      (start_i),
        .value_init_i (value_init_i),
        .lvl_init_i   (lvl_init_i),
        .bkt_i        (bkt_i),
        .bkt_lvl_i    (bkt_lvl_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .conflict_o   (conflict_o),
        .timeout_o    (timeout_o),
        .value_o      (value_o),
        .lvl_o        (lvl_o),
        .ca_wr_o      (ca_wr_o),
        .ca_clause_o  (ca_clause_o),
        .ca_len_o     (ca_len_o),
        .ca_value_o   (ca_value_o),
        .ca_value_i   (ca_value_i),
        .ca_lvl_o     (ca_lvl_o),
        .ca_lvl_i     (ca_lvl_i),
        .ca_impl_o    (ca_impl_o),
        .ca_bkt_o     (ca_bkt_o)
    );

    int total = 0;
    int bad   = 0;

    int cyc = 0, done_cnt = 0, impl_cnt = 0, bkt_cnt = 0;
    int acc_cnt = 0, wr_cnt = 0, both_cnt = 0, pass = 0;
    int done_cyc = 0;
    int mode = 0;
    logic last_conf = 1'b0, last_to = 1'b0;
    logic [NC-1:0]    wr_log  [32];
    logic [NV*2-1:0]  cl_log  [32];
    logic [WCL-1:0]   len_log [32];
    int               wr_cyc  [32];
    logic [NV*3-1:0]  bkt_val = '0;
    logic [NV*WL-1:0] bkt_lvl_seen = '0;

    // Monitor and array model, both on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (done_o) begin
            done_cnt++;
            last_conf = conflict_o;
            last_to   = timeout_o;
            done_cyc  = cyc;
        end
        if (|ca_wr_o) begin
            if (wr_cnt < 32) begin
                wr_log[wr_cnt]  = ca_wr_o;
                cl_log[wr_cnt]  = ca_clause_o;
                len_log[wr_cnt] = ca_len_o;
                wr_cyc[wr_cnt]  = cyc;
            end
            wr_cnt++;
        end
        if (ld_valid_i && ld_ready_o) acc_cnt++;
        if (ca_impl_o && ca_bkt_o) both_cnt++;
        if (ca_bkt_o) begin
            bkt_cnt++;
            bkt_val      = ca_value_o;
            bkt_lvl_seen = ca_lvl_o;
        end
        if (start_i) pass = 0;
        if (ca_impl_o) begin
            impl_cnt++;
            pass++;
            ca_lvl_i = ca_lvl_o;
            case (mode)
                0: ca_value_i = (pass == 1) ? V_A : V_B;
                1: ca_value_i = (pass == 1) ? V_A : V_C;
                default: ca_value_i = (pass % 2 == 1) ? V_A : V_B;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int tgt, input int budget);
        int n = 0;
        while (done_cnt < tgt && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", 128'(done_cnt >= tgt), 128'd1);
    endtask

    logic [15:0] cl_tab  [5];
    logic [4:0]  len_tab [5];

    initial begin
        int w0, d0, i0, b0, a0;
        cl_tab[0] = 16'h0012; len_tab[0] = 5'd2;
        cl_tab[1] = 16'h0848; len_tab[1] = 5'd3;
        cl_tab[2] = 16'h0242; len_tab[2] = 5'd3;
        cl_tab[3] = 16'h0105; len_tab[3] = 5'd3;
        cl_tab[4] = 16'h0224; len_tab[4] = 5'd3;

        rst = 1'b1;
        ld_valid_i = 1'b0; ld_last_i = 1'b0;
        ld_clause_i = '0; ld_len_i = '0;
        start_i = 1'b0; bkt_i = 1'b0; bkt_lvl_i = '0;
        value_init_i = '0; lvl_init_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", {ld_ready_o, busy_o, done_o, conflict_o,
            timeout_o, ca_wr_o, ca_clause_o, ca_len_o, ca_impl_o,
            ca_bkt_o, value_o, ca_value_o}, '0);
        chk("rst_lvl", lvl_o | ca_lvl_o, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ready", 128'(ld_ready_o), 128'd1);
        chk("idle_busy", 128'(busy_o), 128'd0);

        // Five-clause bin, last on the fifth word.
        w0 = wr_cnt;
        d0 = done_cnt;
        for (int k = 0; k < 5; k++) begin
            ld_valid_i  = 1'b1;
            ld_clause_i = cl_tab[k];
            ld_len_i    = len_tab[k];
            ld_last_i   = (k == 4);
            @(posedge clk);
            #1;
        end
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        wait_done(d0 + 1, 30);
        chk("load_rows", 128'(wr_cnt - w0), 128'd8);
        for (int i = 0; i < 8; i++) begin
            chk("load_wr", 128'(wr_log[w0+i]), 128'(NC'(1) << i));
            chk("load_cl", 128'(cl_log[w0+i]),
                (i < 5) ? 128'(cl_tab[i]) : 128'd0);
            chk("load_len", 128'(len_log[w0+i]),
                (i < 5) ? 128'(len_tab[i]) : 128'd0);
        end
        chk("load_done_lat", 128'(done_cyc - wr_cyc[w0+7]), 128'd1);
        chk("load_busy", 128'(busy_o), 128'd0);

        // Converges after three passes.
        mode = 0;
        i0 = impl_cnt;
        d0 = done_cnt;
        value_init_i = V_INIT;
        lvl_init_i   = L_INIT;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(d0 + 1, 40);
        chk("fp_impl", 128'(impl_cnt - i0), 128'd3);
        chk("fp_conf", 128'(last_conf), 128'd0);
        chk("fp_to", 128'(last_to), 128'd0);
        chk("fp_value", 128'(value_o), 128'(V_B));
        chk("fp_lvl", lvl_o, L_INIT);

        // Var 3 goes to 11 on pass 2.
        mode = 1;
        i0 = impl_cnt;
        d0 = done_cnt;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(d0 + 1, 40);
        chk("cf_impl", 128'(impl_cnt - i0), 128'd2);
        chk("cf_conf", 128'(last_conf), 128'd1);
        chk("cf_to", 128'(last_to), 128'd0);
        chk("cf_value", 128'(value_o), 128'(V_C));

        // Oscillating array never settles.
        mode = 2;
        i0 = impl_cnt;
        d0 = done_cnt;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(d0 + 1, 40);
        chk("to_impl", 128'(impl_cnt - i0), 128'd4);
        chk("to_conf", 128'(last_conf), 128'd0);
        chk("to_flag", 128'(last_to), 128'd1);
        chk("to_value", 128'(value_o), 128'(V_B));

        // Backtrack to level 3 with a colliding start.
        i0 = impl_cnt;
        b0 = bkt_cnt;
        d0 = done_cnt;
        bkt_i = 1'b1;
        start_i = 1'b1;
        bkt_lvl_i = 16'd3;
        @(posedge clk);
        #1;
        bkt_i = 1'b0;
        start_i = 1'b0;
        wait_done(d0 + 1, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("bk_pulses", 128'(bkt_cnt - b0), 128'd1);
        chk("bk_drv_val", 128'(bkt_val), 128'(V_K));
        chk("bk_drv_lvl", bkt_lvl_seen, L_K);
        chk("bk_value", 128'(value_o), 128'(V_K));
        chk("bk_lvl", lvl_o, L_K);
        chk("bk_no_impl", 128'(impl_cnt - i0), 128'd0);
        chk("bk_busy", 128'(busy_o), 128'd0);

        // New bin of nine words with no last: eight fit.
        w0 = wr_cnt;
        a0 = acc_cnt;
        d0 = done_cnt;
        for (int k = 0; k < 9; k++) begin
            ld_valid_i  = 1'b1;
            ld_clause_i = 16'(k + 1);
            ld_len_i    = 5'd1;
            if (k == 8) chk("bp_ready9", 128'(ld_ready_o), 128'd0);
            @(posedge clk);
            #1;
        end
        ld_valid_i = 1'b0;
        wait_done(d0 + 1, 20);
        chk("bp_acc", 128'(acc_cnt - a0), 128'd8);
        chk("bp_rows", 128'(wr_cnt - w0), 128'd8);
        chk("bp_wr0", 128'(wr_log[w0]), 128'h01);
        chk("bp_wr7", 128'(wr_log[w0+7]), 128'h80);
        chk("bp_cl7", 128'(cl_log[w0+7]), 128'h0008);

        // Reset while a pass is in flight.
        mode = 0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("pr_impl", 128'(ca_impl_o), 128'd1);
        chk("pr_busy", 128'(busy_o), 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("pr_rst_ctl", {ld_ready_o, busy_o, done_o, conflict_o,
            timeout_o, ca_wr_o, ca_clause_o, ca_len_o, ca_impl_o,
            ca_bkt_o, value_o, ca_value_o}, '0);
        chk("pr_rst_lvl", lvl_o | ca_lvl_o, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("pr_ready", 128'(ld_ready_o), 128'd1);
        chk("impl_bkt_excl", 128'(both_cnt), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
